// File: rtl/uart_reg_bank_pkg.sv
// Shared definitions for the UART register bank: address map, CTRL/STATUS
// bit positions and the Tx handshake FSM encoding.
package uart_reg_pkg;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_TXDATA = 2'd1;
   localparam logic [1:0] ADDR_RXDATA = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_PAR_EN  = 0;
   localparam int CTRL_PAR_ODD = 1;
   localparam int CTRL_RX_IE   = 2;
   localparam int CTRL_TX_IE   = 3;

   localparam int ST_RX_NEMPTY = 0;
   localparam int ST_RX_FULL   = 1;
   localparam int ST_HOLD_FULL = 2;
   localparam int ST_TX_BUSY   = 3;
   localparam int ST_RX_OVR    = 4;
   localparam int ST_PAR_SEEN  = 5;
   localparam int ST_TX_OVF    = 6;
   localparam int ST_CNT_LSB   = 8;

   typedef enum logic {
      TX_IDLE = 1'b0,
      TX_BUSY = 1'b1
   } tx_state_e;

endpackage

// File: rtl/uart_reg_bank_if.sv
// CPU-side bus of the UART register bank: single-cycle strobes, combinational
// read data.
interface uart_reg_bank_if #(
   parameter int BUS_W = 32
);
   logic [1:0]       addr;
   logic             wr_en;
   logic             rd_en;
   logic [BUS_W-1:0] wdata;
   logic [BUS_W-1:0] rdata;

   modport master (output addr, output wr_en, output rd_en, output wdata, input rdata);
   modport slave  (input addr, input wr_en, input rd_en, input wdata, output rdata);
endinterface

// File: rtl/uart_reg_bank_rx_fifo.sv
// Synchronous FIFO for received characters; head entry is presented
// combinationally whenever the FIFO is non-empty.
module uart_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push_ok;
   logic             w_pop_ok;

   // A push at full only lands when a pop frees the slot in the same cycle.
   assign w_push_ok = i_push & (~o_full | i_pop);
   assign w_pop_ok  = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push_ok) r_wptr <= r_wptr + AW'(1);
         if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rptr];
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/uart_reg_bank.sv
// Memory-mapped register bank between the CPU bus and the UART Tx/Rx cores:
// CTRL, double-buffered TXDATA, RXDATA FIFO and STATUS with sticky W1C flags.
module uart_reg_bank
   import uart_reg_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int RX_DEPTH = 4,
   parameter int BUS_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   uart_reg_bank_if.slave    bus,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_parity_err,
   input  logic              rx_done,
   input  logic              tx_done,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_start,
   output logic              parity_en,
   output logic              parity_odd,
   output logic              irq
);

   localparam int CW = $clog2(RX_DEPTH + 1);
   localparam int FW = DATA_W + 1;

   logic [3:0]        r_ctrl;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_full;
   logic [DATA_W-1:0] r_tx_data;
   logic              r_rx_ovr;
   logic              r_par_seen;
   logic              r_tx_ovf;
   logic              r_irq;
   tx_state_e         r_state;
   tx_state_e         w_state_nxt;

   logic              w_wr_ctrl;
   logic              w_wr_tx;
   logic              w_wr_st;
   logic              w_pop;
   logic              w_start;
   logic              w_tx_busy;
   logic              w_tx_accept;
   logic              w_tx_ovf_set;
   logic              w_rx_ovr_set;
   logic              w_fifo_full;
   logic              w_fifo_empty;
   logic [CW-1:0]     w_fifo_count;
   logic [FW-1:0]     w_fifo_head;
   logic [BUS_W-1:0]  w_rdata;
   logic              w_unused;

   assign w_wr_ctrl = bus.wr_en & (bus.addr == ADDR_CTRL);
   assign w_wr_tx   = bus.wr_en & (bus.addr == ADDR_TXDATA);
   assign w_wr_st   = bus.wr_en & (bus.addr == ADDR_STATUS);
   assign w_pop     = bus.rd_en & (bus.addr == ADDR_RXDATA) & ~w_fifo_empty;

   uart_rx_fifo #(
      .WIDTH (FW),
      .DEPTH (RX_DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (rx_done),
      .i_pop   (w_pop),
      .i_wdata ({rx_parity_err, rx_data}),
      .o_rdata (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) r_state <= TX_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         TX_IDLE: if (r_hold_full) w_state_nxt = TX_BUSY;
         TX_BUSY: if (tx_done)     w_state_nxt = TX_IDLE;
         default: w_state_nxt = TX_IDLE;
      endcase
   end

   // The start cycle drives the holding value directly so tx_data is valid
   // together with tx_start; reset suppresses the pulse in its own cycle.
   always_comb begin
      w_start   = 1'b0;
      w_tx_busy = 1'b0;
      case (r_state)
         TX_IDLE: w_start   = r_hold_full & ~reset;
         TX_BUSY: w_tx_busy = 1'b1;
         default: ;
      endcase
   end

   assign w_tx_accept  = w_wr_tx & (~r_hold_full | w_start);
   assign w_tx_ovf_set = w_wr_tx & r_hold_full & ~w_start;
   assign w_rx_ovr_set = rx_done & w_fifo_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl      <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_tx_data   <= '0;
         r_rx_ovr    <= 1'b0;
         r_par_seen  <= 1'b0;
         r_tx_ovf    <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         if (w_wr_ctrl)   r_ctrl <= bus.wdata[3:0];
         if (w_tx_accept) r_hold <= bus.wdata[DATA_W-1:0];
         if (w_tx_accept)  r_hold_full <= 1'b1;
         else if (w_start) r_hold_full <= 1'b0;
         if (w_start) r_tx_data <= r_hold;
         // Setting has priority over a simultaneous write-1-to-clear.
         r_rx_ovr   <= (r_rx_ovr   & ~(w_wr_st & bus.wdata[ST_RX_OVR]))   | w_rx_ovr_set;
         r_par_seen <= (r_par_seen & ~(w_wr_st & bus.wdata[ST_PAR_SEEN])) | (rx_done & rx_parity_err);
         r_tx_ovf   <= (r_tx_ovf   & ~(w_wr_st & bus.wdata[ST_TX_OVF]))   | w_tx_ovf_set;
         r_irq      <= (r_ctrl[CTRL_RX_IE] & ~w_fifo_empty) | (r_ctrl[CTRL_TX_IE] & ~r_hold_full);
      end
   end

   always_comb begin
      w_rdata = '0;
      case (bus.addr)
         ADDR_CTRL:   w_rdata[3:0] = r_ctrl;
         ADDR_TXDATA: w_rdata[DATA_W:0] = {w_tx_busy, r_hold};
         ADDR_RXDATA: if (!w_fifo_empty) w_rdata[DATA_W:0] = w_fifo_head;
         ADDR_STATUS: begin
            w_rdata[ST_RX_NEMPTY] = ~w_fifo_empty;
            w_rdata[ST_RX_FULL]   = w_fifo_full;
            w_rdata[ST_HOLD_FULL] = r_hold_full;
            w_rdata[ST_TX_BUSY]   = w_tx_busy;
            w_rdata[ST_RX_OVR]    = r_rx_ovr;
            w_rdata[ST_PAR_SEEN]  = r_par_seen;
            w_rdata[ST_TX_OVF]    = r_tx_ovf;
            w_rdata[ST_CNT_LSB +: 8] = 8'(w_fifo_count);
         end
         default: w_rdata = '0;
      endcase
   end

   assign bus.rdata  = w_rdata;
   assign tx_start   = w_start;
   assign tx_data    = w_start ? r_hold : r_tx_data;
   assign parity_en  = r_ctrl[CTRL_PAR_EN];
   assign parity_odd = r_ctrl[CTRL_PAR_ODD];
   assign irq        = r_irq;
   assign w_unused   = &{1'b0, bus.wdata[BUS_W-1:DATA_W]};

endmodule
